mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the MIPS pipeline.
- Sits directly downstream of the EX-stage 3-to-1 forwarding muxes and consumes their forwarded rs/rt values as OpA/OpB.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the HI/LO architectural registers.
- Busy drives the hazard unit, which stalls dependent MFHI/MFLO instructions.

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/mult_div_unit_abs.sv | 10 +
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings and constants for the iterative multiply/divide unit
package mult_div_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;

    // MULT and DIV (op[0]==0) treat operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_abs.sv
// rtl/mult_div_unit_abs.sv - combinational 32-bit conditional two's-complement negate
module md_abs32 (
    input  logic [31:0] value_i,
    input  logic        neg_en_i,
    output logic [31:0] result_o
);

    assign result_o = neg_en_i ? (~value_i + 32'd1) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO
// Optional macro MULT_DIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
import mult_div_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q;
    logic        sa_q, sb_q;
    logic [31:0] acc_q, acc_d;
    logic [31:0] low_q, low_d;
    logic [31:0] opnd_q, opnd_d;
    logic        commit_q;
    logic [31:0] res_hi_q, res_lo_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        launch, busy;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_tmp;
    logic [31:0] div_sub;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] fix_hi_in, fix_lo_in, neg_hi, neg_lo;
    logic        q_neg, hi_neg, borrow, div0;
    logic [31:0] res_hi, res_lo;

    // The commit cycle keeps Busy high so MFHI/MFLO stall until Hi/Lo land
    assign busy   = (state_q != S_IDLE) | commit_q;
    assign launch = (state_q == S_IDLE) & ~commit_q & Start;
    assign a_neg  = op_is_signed(Op) & OpA[31];
    assign b_neg  = op_is_signed(Op) & OpB[31];

    md_abs32 u_abs_a (.value_i(OpA), .neg_en_i(a_neg), .result_o(mag_a));
    md_abs32 u_abs_b (.value_i(OpB), .neg_en_i(b_neg), .result_o(mag_b));

    assign mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_tmp = {acc_q, low_q[31]};
    assign div_ge  = div_tmp >= {1'b0, opnd_q};
    assign div_sub = div_tmp[31:0] - opnd_q;

`ifdef MULT_DIV_EARLY_OUT_EN
    logic [31:0] rest_q, rest_d;
    logic [5:0]  fix_shamt;

    assign fix_shamt = 6'(ITER) - cnt_q;
    assign prod_fix  = {acc_q, low_q} >> fix_shamt;
`else
    assign prod_fix  = {acc_q, low_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
`ifdef MULT_DIV_EARLY_OUT_EN
        rest_d  = rest_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_RUN;
                    cnt_d   = 6'd0;
                    acc_d   = 32'd0;
                    low_d   = op_is_div(Op) ? mag_a : mag_b;
                    opnd_d  = op_is_div(Op) ? mag_b : mag_a;
`ifdef MULT_DIV_EARLY_OUT_EN
                    rest_d  = mag_b;
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (op_is_div(op_q)) begin
                    acc_d = div_ge ? div_sub : div_tmp[31:0];
                    low_d = {low_q[30:0], div_ge};
                end else begin
                    {acc_d, low_d} = {mul_sum, low_q[31:1]};
                end
`ifdef MULT_DIV_EARLY_OUT_EN
                rest_d = rest_q >> 1;
                if (cnt_q == LAST_CNT ||
                    (!op_is_div(op_q) && rest_q[31:1] == 31'd0)) begin
                    state_d = S_FIX;
                end
`else
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign correction: remainder follows the dividend, product/quotient take signA^signB
    assign q_neg     = sa_q ^ sb_q;
    assign hi_neg    = op_is_div(op_q) ? sa_q : q_neg;
    assign fix_hi_in = op_is_div(op_q) ? acc_q : prod_fix[63:32];
    assign fix_lo_in = op_is_div(op_q) ? low_q : prod_fix[31:0];
    assign div0      = op_is_div(op_q) & (opnd_q == 32'd0);

    md_abs32 u_fix_hi (.value_i(fix_hi_in), .neg_en_i(hi_neg), .result_o(neg_hi));
    md_abs32 u_fix_lo (.value_i(fix_lo_in), .neg_en_i(q_neg),  .result_o(neg_lo));

    // 64-bit negate: the high word only absorbs the +1 carry when the low word is zero
    assign borrow = ~op_is_div(op_q) & q_neg & (fix_lo_in != 32'd0);
    assign res_hi = neg_hi - {31'd0, borrow};
    assign res_lo = div0 ? DIVZ_QUOT : neg_lo;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= OP_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= 32'd0;
            low_q    <= 32'd0;
            opnd_q   <= 32'd0;
            commit_q <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MULT_DIV_EARLY_OUT_EN
            rest_q   <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
`ifdef MULT_DIV_EARLY_OUT_EN
            rest_q   <= rest_d;
`endif
            if (launch) begin
                op_q <= Op;
                sa_q <= a_neg;
                sb_q <= b_neg;
            end
            commit_q <= (state_q == S_FIX);
            if (state_q == S_FIX) begin
                res_hi_q <= res_hi;
                res_lo_q <= res_lo;
            end
            done_q <= commit_q;
            if (commit_q) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end else if (!busy) begin
                if (HiWrite) hi_q <= WrData;
                if (LoWrite) lo_q <= WrData;
            end
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy;
    assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed-vector bench for mult_div_unit
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OpA, OpB, WrData;
    logic        HiWrite, LoWrite;
    logic [31:0] Hi, Lo;
    logic        Busy, Done;

    int n_vec  = 0;
    int n_miss = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Drives Start before edge 0 and returns after sampling edge 0
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        tick();
        Start = 1'b0; OpA = 32'hDEAD_BEEF; OpB = 32'h0BAD_F00D;
    endtask

    // Edges 1..34 after start_op: Busy high through 33, result + Done at 34, Done gone at 35
    task automatic finish_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int first_edge);
        logic busy_ok;
        busy_ok = 1'b1;
        for (int e = first_edge; e <= 33; e++) begin
            tick();
            if (Busy !== 1'b1 || Done !== 1'b0) busy_ok = 1'b0;
        end
        tick();
        check_val({tag, " busy window"}, {31'd0, busy_ok}, 32'd1);
        check_val({tag, " done@34"}, {31'd0, Done}, 32'd1);
        check_val({tag, " busy@34"}, {31'd0, Busy}, 32'd0);
        check_val({tag, " hi"}, Hi, exp_hi);
        check_val({tag, " lo"}, Lo, exp_lo);
        tick();
        check_val({tag, " done@35"}, {31'd0, Done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start_op(op, a, b);
        finish_op(tag, exp_hi, exp_lo, 1);
    endtask

    initial begin
        int dones;
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
        tick();
        tick();
        check_val("reset hi", Hi, 32'd0);
        check_val("reset lo", Lo, 32'd0);
        check_val("reset busy", {31'd0, Busy}, 32'd0);
        check_val("reset done", {31'd0, Done}, 32'd0);
        Reset = 1'b1;
        tick();

        HiWrite = 1'b1; WrData = 32'h0000_5555;
        tick();
        HiWrite = 1'b0; LoWrite = 1'b1; WrData = 32'h0000_7777;
        tick();
        LoWrite = 1'b0;
        check_val("mthi", Hi, 32'h0000_5555);
        check_val("mtlo", Lo, 32'h0000_7777);

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu /0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("mult -1x-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

        // Start together with MTHI: write lands at edge 0, result overwrites at edge 34
        HiWrite = 1'b1; WrData = 32'h0000_1111;
        Start = 1'b1; Op = 2'b01; OpA = 32'h0001_0000; OpB = 32'h0001_0000;
        tick();
        Start = 1'b0; HiWrite = 1'b0;
        check_val("start+mthi hi@0", Hi, 32'h0000_1111);
        finish_op("start+mthi", 32'd1, 32'd0, 1);

        // Start and MTHI while busy are ignored
        start_op(2'b01, 32'd2, 32'd3);
        for (int e = 1; e <= 9; e++) tick();
        Start = 1'b1; Op = 2'b11; OpA = 32'd9; OpB = 32'd3;
        HiWrite = 1'b1; WrData = 32'h0000_AAAA;
        tick();
        Start = 1'b0; HiWrite = 1'b0;
        finish_op("busy ignore", 32'd0, 32'd6, 11);

        // Reset mid-operation abandons the result
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        for (int e = 1; e <= 14; e++) tick();
        Reset = 1'b0;
        tick();
        check_val("abort hi", Hi, 32'd0);
        check_val("abort lo", Lo, 32'd0);
        check_val("abort busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1;
        dones = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (Done === 1'b1) dones++;
        end
        check_val("abort no done", 32'(dones), 32'd0);
        check_val("abort hi held", Hi, 32'd0);
        run_op("multu 4x4", 2'b01, 32'd4, 32'd4, 32'd0, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
